qspi_lane_distributor: RTL and testbench

Parametrised successor to the single-width parallelizer. It deserialises a QSPI nibble stream into one key and then a sequence of data words. It programs every encrypter lane with the key and a per-lane rotation offset, then dispatches data words round-robin to the lanes under a valid/ready handshake with backpressure to the QSPI source. It sits between the top-level QSPI input and the encrypter array.

---
 rtl/qspi_lane_distributor.sv | 187 ++++++++++++++++++
 tb/tb_qspi_lane_distributor.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_lane_distributor.sv
// qspi_lane_distributor
//
// Deserialises a QSPI nibble stream into one key and then a sequence of
// data words. After the key is loaded, every encrypter lane is programmed
// with that key and its own rotation offset. Data words are then dealt out
// round-robin to the lanes under a valid/ready handshake. qspi_ready is
// withheld while a word waits for its lane, which pushes back on the source.
//
// Ports:
//   clk           system clock, rising edge active
//   reset         asynchronous, active-high reset
//   prog          one-cycle pulse: start a key load, abandoning any activity
//   qspi_data     incoming nibble, most significant nibble first
//   qspi_sending  source presents a valid nibble
//   qspi_ready    block accepts a nibble this cycle
//   lane_key      key bus shared by all lanes
//   lane_rot      per-lane rotation offset, lane i at [i*ROT_WIDTH +: ROT_WIDTH]
//   lane_program  per-lane program strobe
//   lane_data     data word bus shared by all lanes
//   lane_valid    one-hot data valid, one bit per lane
//   lane_ready    per-lane ready to accept a word
//   word_count    words dispatched since the last key load, wraps at 16 bits
//   state_out     current FSM state, for debug

module qspi_lane_distributor #(
    parameter int NUM_LANES  = 4,
    parameter int LANE_WIDTH = 32,
    parameter int KEY_WIDTH  = 32,
    parameter int QSPI_WIDTH = 4,
    parameter int ROT_WIDTH  = 5,
    parameter int ROT_STEP   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           prog,
    input  logic [QSPI_WIDTH-1:0]          qspi_data,
    input  logic                           qspi_sending,
    output logic                           qspi_ready,
    output logic [KEY_WIDTH-1:0]           lane_key,
    output logic [NUM_LANES*ROT_WIDTH-1:0] lane_rot,
    output logic [NUM_LANES-1:0]           lane_program,
    output logic [LANE_WIDTH-1:0]          lane_data,
    output logic [NUM_LANES-1:0]           lane_valid,
    input  logic [NUM_LANES-1:0]           lane_ready,
    output logic [15:0]                    word_count,
    output logic [2:0]                     state_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEY_LOAD = 3'd1,
        PROGRAM  = 3'd2,
        STREAM   = 3'd3,
        DISPATCH = 3'd4
    } state_t;

    // One shift register serves both the key and the data words, so it is
    // sized for the wider of the two.
    localparam int SHIFT_WIDTH  = (KEY_WIDTH > LANE_WIDTH) ? KEY_WIDTH : LANE_WIDTH;
    localparam int KEY_NIBBLES  = KEY_WIDTH / QSPI_WIDTH;
    localparam int WORD_NIBBLES = LANE_WIDTH / QSPI_WIDTH;
    localparam int MAX_NIBBLES  = SHIFT_WIDTH / QSPI_WIDTH;
    localparam int CNT_WIDTH    = $clog2(MAX_NIBBLES + 1);
    localparam int PTR_WIDTH    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [CNT_WIDTH-1:0] KEY_LAST  = CNT_WIDTH'(KEY_NIBBLES - 1);
    localparam logic [CNT_WIDTH-1:0] WORD_LAST = CNT_WIDTH'(WORD_NIBBLES - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(NUM_LANES - 1);

    // The rotation offsets depend only on parameters, so the whole table is
    // built at elaboration. Lane i rotates by (i*ROT_STEP) mod KEY_WIDTH.
    function automatic logic [NUM_LANES*ROT_WIDTH-1:0] build_rot_table();
        logic [NUM_LANES*ROT_WIDTH-1:0] table_bits;
        table_bits = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            table_bits[i*ROT_WIDTH +: ROT_WIDTH] = ROT_WIDTH'((i * ROT_STEP) % KEY_WIDTH);
        end
        return table_bits;
    endfunction

    localparam logic [NUM_LANES*ROT_WIDTH-1:0] ROT_TABLE = build_rot_table();

    state_t                 state;
    logic [SHIFT_WIDTH-1:0] shift_reg;
    logic [SHIFT_WIDTH-1:0] next_shift;
    logic [CNT_WIDTH-1:0]   nibble_cnt;
    logic [PTR_WIDTH-1:0]   ptr;
    logic                   accept;

    // The source may only push nibbles while a key or a word is being
    // assembled; everywhere else it is held off.
    assign qspi_ready = (state == KEY_LOAD) || (state == STREAM);
    assign state_out  = state;

    // prog wins over a nibble arriving in the same cycle, so that nibble is
    // treated as never accepted.
    assign accept     = qspi_sending && qspi_ready && !prog;

    // The shift written as shift-and-or so it stays width-safe even when the
    // register holds a single nibble.
    assign next_shift = (shift_reg << QSPI_WIDTH) | SHIFT_WIDTH'(qspi_data);

    // Main FSM. All lane-facing outputs are registered here. A prog pulse
    // restarts key loading from any state, drops any partial word and any
    // pending dispatch, but leaves lane_key alone until a new key completes.
    // A pending word waits only for the lane the pointer names; other lanes'
    // ready bits never let it skip ahead, which keeps order strictly
    // round-robin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            nibble_cnt   <= '0;
            ptr          <= '0;
            lane_key     <= '0;
            lane_rot     <= '0;
            lane_program <= '0;
            lane_data    <= '0;
            lane_valid   <= '0;
            word_count   <= '0;
        end else if (prog) begin
            state        <= KEY_LOAD;
            shift_reg    <= '0;
            nibble_cnt   <= '0;
            lane_program <= '0;
            lane_valid   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end

                KEY_LOAD: begin
                    if (accept) begin
                        if (nibble_cnt == KEY_LAST) begin
                            lane_key     <= next_shift[KEY_WIDTH-1:0];
                            shift_reg    <= '0;
                            nibble_cnt   <= '0;
                            lane_program <= '1;
                            lane_rot     <= ROT_TABLE;
                            word_count   <= '0;
                            ptr          <= '0;
                            state        <= PROGRAM;
                        end else begin
                            shift_reg  <= next_shift;
                            nibble_cnt <= nibble_cnt + CNT_WIDTH'(1);
                        end
                    end
                end

                PROGRAM: begin
                    lane_program <= '0;
                    state        <= STREAM;
                end

                STREAM: begin
                    if (accept) begin
                        if (nibble_cnt == WORD_LAST) begin
                            lane_data  <= next_shift[LANE_WIDTH-1:0];
                            lane_valid <= NUM_LANES'(1) << ptr;
                            shift_reg  <= '0;
                            nibble_cnt <= '0;
                            state      <= DISPATCH;
                        end else begin
                            shift_reg  <= next_shift;
                            nibble_cnt <= nibble_cnt + CNT_WIDTH'(1);
                        end
                    end
                end

                DISPATCH: begin
                    if (lane_ready[ptr]) begin
                        lane_valid <= '0;
                        ptr        <= (ptr == PTR_LAST) ? '0 : ptr + PTR_WIDTH'(1);
                        word_count <= word_count + 16'd1;
                        state      <= STREAM;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_lane_distributor.sv
// tb_qspi_lane_distributor
//
// Directed bench for qspi_lane_distributor. One instance uses the default
// parameters; a second uses three 16-bit lanes with a rotation step of 11.
// Round-robin dispatch is driven from vector tables; stalls, mid-word pauses,
// re-programming and asynchronous reset are hand-written sequences.

module tb_qspi_lane_distributor;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  exp_valid;
        logic [15:0] exp_count;
    } vec_t;

    logic        clk;
    logic        reset;

    // Default-parameter instance
    logic        prog;
    logic [3:0]  qspi_data;
    logic        qspi_sending;
    logic        qspi_ready;
    logic [31:0] lane_key;
    logic [19:0] lane_rot;
    logic [3:0]  lane_program;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic [3:0]  lane_ready;
    logic [15:0] word_count;
    logic [2:0]  state_out;

    // Three-lane, 16-bit instance
    logic        s_prog;
    logic [3:0]  s_qspi_data;
    logic        s_qspi_sending;
    logic        s_qspi_ready;
    logic [31:0] s_lane_key;
    logic [14:0] s_lane_rot;
    logic [2:0]  s_lane_program;
    logic [15:0] s_lane_data;
    logic [2:0]  s_lane_valid;
    logic [2:0]  s_lane_ready;
    logic [15:0] s_word_count;
    logic [2:0]  s_state_out;

    int vec_count;
    int miss_count;
    int cyc;

    qspi_lane_distributor dut (
        .clk          (clk),
        .reset        (reset),
        .prog         (prog),
        .qspi_data    (qspi_data),
        .qspi_sending (qspi_sending),
        .qspi_ready   (qspi_ready),
        .lane_key     (lane_key),
        .lane_rot     (lane_rot),
        .lane_program (lane_program),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .lane_ready   (lane_ready),
        .word_count   (word_count),
        .state_out    (state_out)
    );

    qspi_lane_distributor #(
        .NUM_LANES  (3),
        .LANE_WIDTH (16),
        .KEY_WIDTH  (32),
        .QSPI_WIDTH (4),
        .ROT_WIDTH  (5),
        .ROT_STEP   (11)
    ) dut_sweep (
        .clk          (clk),
        .reset        (reset),
        .prog         (s_prog),
        .qspi_data    (s_qspi_data),
        .qspi_sending (s_qspi_sending),
        .qspi_ready   (s_qspi_ready),
        .lane_key     (s_lane_key),
        .lane_rot     (s_lane_rot),
        .lane_program (s_lane_program),
        .lane_data    (s_lane_data),
        .lane_valid   (s_lane_valid),
        .lane_ready   (s_lane_ready),
        .word_count   (s_word_count),
        .state_out    (s_state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used to measure per-word latency.
    always @(posedge clk) begin
        cyc++;
    end

    // Safety net so the run always ends even if the clock stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sends the top 'nibbles' nibbles of value to the default instance, MSB first.
    task automatic applyStimulus(input logic [31:0] value, input int nibbles);
        for (int n = 0; n < nibbles; n++) begin
            qspi_sending = 1'b1;
            qspi_data    = value[31-4*n -: 4];
            tick();
        end
        qspi_sending = 1'b0;
    endtask

    // Same as applyStimulus, for the three-lane instance.
    task automatic applySweepStimulus(input logic [31:0] value, input int nibbles);
        for (int n = 0; n < nibbles; n++) begin
            s_qspi_sending = 1'b1;
            s_qspi_data    = value[31-4*n -: 4];
            tick();
        end
        s_qspi_sending = 1'b0;
    endtask

    initial begin
        vec_t rr_table[4];
        vec_t sweep_table[4];
        int   exp_rot[4];
        int   exp_sweep_rot[3];
        int   start_cyc;
        int   stall_bad;
        int   pause_bad;

        rr_table[0] = '{32'hA000_0000, 4'b0001, 16'd1};
        rr_table[1] = '{32'hA000_0001, 4'b0010, 16'd2};
        rr_table[2] = '{32'hA000_0002, 4'b0100, 16'd3};
        rr_table[3] = '{32'hA000_0003, 4'b1000, 16'd4};

        sweep_table[0] = '{32'h1111_0000, 4'b0001, 16'd1};
        sweep_table[1] = '{32'h2222_0000, 4'b0010, 16'd2};
        sweep_table[2] = '{32'h3333_0000, 4'b0100, 16'd3};
        sweep_table[3] = '{32'h4444_0000, 4'b0001, 16'd4};

        exp_rot       = '{0, 3, 6, 9};
        exp_sweep_rot = '{0, 11, 22};

        vec_count      = 0;
        miss_count     = 0;
        cyc            = 0;
        reset          = 1'b1;
        prog           = 1'b0;
        qspi_data      = 4'h0;
        qspi_sending   = 1'b0;
        lane_ready     = 4'b0000;
        s_prog         = 1'b0;
        s_qspi_data    = 4'h0;
        s_qspi_sending = 1'b0;
        s_lane_ready   = 3'b000;

        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("reset_state", state_out, 0);
        checkOutput("reset_ready", qspi_ready, 0);
        checkOutput("reset_key", lane_key, 0);
        checkOutput("reset_valid", lane_valid, 0);
        checkOutput("reset_count", word_count, 0);

        reset = 1'b0;
        tick();
        qspi_sending = 1'b1;
        qspi_data    = 4'hF;
        tick();
        qspi_sending = 1'b0;
        checkOutput("idle_holds", state_out, 0);
        checkOutput("idle_not_ready", qspi_ready, 0);

        $display("[TB] key load");
        prog = 1'b1;
        tick();
        prog = 1'b0;
        checkOutput("keyload_state", state_out, 1);
        checkOutput("keyload_ready", qspi_ready, 1);
        applyStimulus(32'h1234_5678, 7);
        checkOutput("key_after7_state", state_out, 1);
        checkOutput("key_after7_key", lane_key, 0);
        applyStimulus(32'h8000_0000, 1);
        checkOutput("program_state", state_out, 2);
        checkOutput("program_key", lane_key, 32'h1234_5678);
        checkOutput("program_strobe", lane_program, 4'b1111);
        checkOutput("program_count", word_count, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("program_rot%0d", i), lane_rot[i*5 +: 5], exp_rot[i]);
        end
        tick();
        checkOutput("stream_state", state_out, 3);
        checkOutput("program_strobe_off", lane_program, 0);
        checkOutput("rot_held", lane_rot[15 +: 5], 9);

        $display("[TB] round-robin table");
        lane_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            start_cyc = cyc;
            applyStimulus(rr_table[i].word, 8);
            checkOutput($sformatf("rr%0d_state", i), state_out, 4);
            checkOutput($sformatf("rr%0d_data", i), lane_data, rr_table[i].word);
            checkOutput($sformatf("rr%0d_valid", i), lane_valid, rr_table[i].exp_valid);
            checkOutput($sformatf("rr%0d_backpressure", i), qspi_ready, 0);
            tick();
            checkOutput($sformatf("rr%0d_done_state", i), state_out, 3);
            checkOutput($sformatf("rr%0d_valid_off", i), lane_valid, 0);
            checkOutput($sformatf("rr%0d_count", i), word_count, rr_table[i].exp_count);
            checkOutput($sformatf("rr%0d_cycles", i), cyc - start_cyc, 9);
        end

        $display("[TB] backpressure on lane 1");
        applyStimulus(32'hB000_0000, 8);
        checkOutput("bp_lane0_valid", lane_valid, 4'b0001);
        tick();
        lane_ready = 4'b1101;
        applyStimulus(32'hB000_0001, 8);
        checkOutput("bp_valid", lane_valid, 4'b0010);
        qspi_sending = 1'b1;
        qspi_data    = 4'hF;
        stall_bad    = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (lane_valid !== 4'b0010 || qspi_ready !== 1'b0 ||
                lane_data !== 32'hB000_0001 || state_out !== 3'd4)
                stall_bad++;
        end
        qspi_sending = 1'b0;
        checkOutput("bp_stall_hold", stall_bad, 0);
        lane_ready = 4'b1111;
        tick();
        checkOutput("bp_release_state", state_out, 3);
        checkOutput("bp_release_count", word_count, 6);
        applyStimulus(32'hB000_0002, 8);
        checkOutput("bp_next_lane", lane_valid, 4'b0100);
        checkOutput("bp_next_data", lane_data, 32'hB000_0002);
        tick();

        $display("[TB] pause mid-word");
        applyStimulus(32'hC123_4567, 3);
        qspi_data = 4'h9;
        pause_bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (lane_valid !== 4'b0000 || state_out !== 3'd3) pause_bad++;
        end
        checkOutput("pause_quiet", pause_bad, 0);
        applyStimulus(32'h3456_7000, 5);
        checkOutput("pause_state", state_out, 4);
        checkOutput("pause_data", lane_data, 32'hC123_4567);
        checkOutput("pause_valid", lane_valid, 4'b1000);
        tick();
        checkOutput("pause_count", word_count, 8);

        $display("[TB] re-prog mid-word");
        applyStimulus(32'hDDDD_D000, 5);
        prog         = 1'b1;
        qspi_sending = 1'b1;
        qspi_data    = 4'hE;
        tick();
        prog         = 1'b0;
        qspi_sending = 1'b0;
        checkOutput("reprog_state", state_out, 1);
        checkOutput("reprog_key_kept", lane_key, 32'h1234_5678);
        applyStimulus(32'h89AB_CDEF, 7);
        checkOutput("reprog_after7_state", state_out, 1);
        checkOutput("reprog_after7_key", lane_key, 32'h1234_5678);
        applyStimulus(32'hF000_0000, 1);
        checkOutput("reprog_program", state_out, 2);
        checkOutput("reprog_new_key", lane_key, 32'h89AB_CDEF);
        checkOutput("reprog_count", word_count, 0);
        tick();
        applyStimulus(32'hE000_0001, 8);
        checkOutput("reprog_ptr0", lane_valid, 4'b0001);
        checkOutput("reprog_data", lane_data, 32'hE000_0001);
        tick();
        checkOutput("reprog_count1", word_count, 1);

        $display("[TB] prog during dispatch");
        lane_ready = 4'b1101;
        applyStimulus(32'hA5A5_A5A5, 8);
        checkOutput("pd_valid", lane_valid, 4'b0010);
        prog = 1'b1;
        tick();
        prog = 1'b0;
        checkOutput("pd_state", state_out, 1);
        checkOutput("pd_valid_cleared", lane_valid, 0);
        checkOutput("pd_key_kept", lane_key, 32'h89AB_CDEF);
        applyStimulus(32'h0F0F_0F0F, 8);
        checkOutput("pd_new_key", lane_key, 32'h0F0F_0F0F);
        tick();

        $display("[TB] async reset during dispatch");
        lane_ready = 4'b0000;
        applyStimulus(32'h1212_1212, 8);
        checkOutput("ar_pre_state", state_out, 4);
        checkOutput("ar_pre_valid", lane_valid, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_state", state_out, 0);
        checkOutput("ar_ready", qspi_ready, 0);
        checkOutput("ar_key", lane_key, 0);
        checkOutput("ar_rot", lane_rot, 0);
        checkOutput("ar_data", lane_data, 0);
        checkOutput("ar_valid", lane_valid, 0);
        checkOutput("ar_count", word_count, 0);
        checkOutput("ar_program", lane_program, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] three-lane sweep");
        s_prog = 1'b1;
        tick();
        s_prog = 1'b0;
        checkOutput("sw_ready", s_qspi_ready, 1);
        applySweepStimulus(32'hCAFE_F00D, 8);
        checkOutput("sw_program_state", s_state_out, 2);
        checkOutput("sw_key", s_lane_key, 32'hCAFE_F00D);
        checkOutput("sw_strobe", s_lane_program, 3'b111);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("sw_rot%0d", i), s_lane_rot[i*5 +: 5], exp_sweep_rot[i]);
        end
        tick();
        s_lane_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            start_cyc = cyc;
            applySweepStimulus(sweep_table[i].word, 4);
            checkOutput($sformatf("sw%0d_state", i), s_state_out, 4);
            checkOutput($sformatf("sw%0d_data", i), s_lane_data, sweep_table[i].word[31:16]);
            checkOutput($sformatf("sw%0d_valid", i), s_lane_valid, sweep_table[i].exp_valid[2:0]);
            tick();
            checkOutput($sformatf("sw%0d_count", i), s_word_count, sweep_table[i].exp_count);
            checkOutput($sformatf("sw%0d_cycles", i), cyc - start_cyc, 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
